// File: rtl/sram_512x28_host_ctrl_pkg.sv
// Shared types and constants for the 512x28 SRAM host controller.
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    RESET_WAIT = 2'd0,
    INIT       = 2'd1,
    IDLE       = 2'd2
  } ctrl_state_e;

  localparam int unsigned SramAw    = 9;
  localparam int unsigned SramDw    = 28;
  localparam int unsigned SramDepth = 512;

  // Macro margin/timing controls are held at their nominal settings.
  localparam logic [2:0] SramMcDefault     = 3'b000;
  localparam logic [1:0] SramWaDefault     = 2'b00;
  localparam logic [1:0] SramWpulseDefault = 2'b00;

endpackage

// File: rtl/sram_512x28_host_ctrl_init_seq.sv
// Init address sequencer: walks 0..Depth-1 once per start, then drops busy.
module sram_init_seq
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned Depth = SramDepth,
  parameter int unsigned Aw    = SramAw
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          start,
  output logic          busy,
  output logic [Aw-1:0] addr,
  output logic          last
);

  // One spare bit so the completion compare never relies on wrap-around.
  localparam logic [Aw:0] LastCnt = Depth - 1;
  localparam logic [Aw:0] CntOne  = 1;

  logic [Aw:0] cnt_r;
  logic        busy_r;

  // Counter and busy flag; clear beats start, start restarts from address 0.
  always_ff @(posedge clk) begin
    if (clear) begin
      cnt_r  <= '0;
      busy_r <= 1'b0;
    end else if (start) begin
      cnt_r  <= '0;
      busy_r <= 1'b1;
    end else if (busy_r) begin
      if (cnt_r == LastCnt) begin
        cnt_r  <= '0;
        busy_r <= 1'b0;
      end else begin
        cnt_r  <= cnt_r + CntOne;
        busy_r <= 1'b1;
      end
    end else begin
      cnt_r  <= cnt_r;
      busy_r <= busy_r;
    end
  end

  assign busy = busy_r;
  assign addr = cnt_r[Aw-1:0];
  assign last = busy_r && (cnt_r == LastCnt);

endmodule

// File: rtl/sram_512x28_host_ctrl.sv
// Host-side controller for the 512x28 bit-write-enable SRAM macro.
module sram_512x28_host_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned   Depth       = SramDepth,
  parameter int unsigned   Aw          = SramAw,
  parameter int unsigned   Dw          = SramDw,
  parameter bit            InitOnReset = 1'b1,
  parameter logic [Dw-1:0] InitValue   = '0,
  parameter logic [2:0]    McVal       = SramMcDefault,
  parameter logic [1:0]    WpulseVal   = SramWpulseDefault,
  parameter logic [1:0]    WaVal       = SramWaDefault
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_i,
  output logic          gnt_o,
  input  logic          we_i,
  input  logic [Aw-1:0] addr_i,
  input  logic [Dw-1:0] wdata_i,
  input  logic [Dw-1:0] wmask_i,
  output logic          rvalid_o,
  output logic [Dw-1:0] rdata_o,
  input  logic          init_req_i,
  output logic          init_done_o,
  output logic          sram_ren_o,
  output logic          sram_wen_o,
  output logic [Aw-1:0] sram_adr_o,
  output logic [Dw-1:0] sram_din_o,
  output logic [Dw-1:0] sram_wbeb_o,
  input  logic [Dw-1:0] sram_q_i,
  output logic [2:0]    sram_mc_o,
  output logic          sram_mcen_o,
  output logic          sram_clkbyp_o,
  output logic [1:0]    sram_wa_o,
  output logic [1:0]    sram_wpulse_o,
  output logic          sram_wpulseen_o,
  output logic          sram_fwen_o
);

  ctrl_state_e   state_r;
  logic          start_s;
  logic          init_busy_s;
  logic          init_last_s;
  logic [Aw-1:0] init_addr_s;
  logic          rvalid_r;
  logic [Dw-1:0] hold_r;

  sram_init_seq #(
    .Depth (Depth),
    .Aw    (Aw)
  ) u_init_seq (
    .clk   (clk_i),
    .clear (rst_i),
    .start (start_s),
    .busy  (init_busy_s),
    .addr  (init_addr_s),
    .last  (init_last_s)
  );

  // Control FSM: reset wait, optional init pass, then idle servicing the host.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= RESET_WAIT;
    end else begin
      case (state_r)
        RESET_WAIT: state_r <= InitOnReset ? INIT : IDLE;
        INIT:       state_r <= init_last_s ? IDLE : INIT;
        IDLE:       state_r <= init_req_i ? INIT : IDLE;
        default:    state_r <= RESET_WAIT;
      endcase
    end
  end

  // Macro strobes, grant and sequencer start, decoded from state and the live request.
  always_comb begin
    gnt_o       = 1'b0;
    start_s     = 1'b0;
    sram_ren_o  = 1'b0;
    sram_wen_o  = 1'b0;
    sram_adr_o  = '0;
    sram_din_o  = '0;
    sram_wbeb_o = '1;
    if (rst_i) begin
      start_s = 1'b0;
    end else begin
      case (state_r)
        RESET_WAIT: start_s = InitOnReset;
        INIT: begin
          if (init_busy_s) begin
            sram_wen_o  = 1'b1;
            sram_adr_o  = init_addr_s;
            sram_din_o  = InitValue;
            sram_wbeb_o = '0;
          end else begin
            sram_wen_o  = 1'b0;
          end
        end
        IDLE: begin
          gnt_o   = ~init_req_i;
          start_s = init_req_i;
          if (req_i && !init_req_i) begin
            sram_adr_o = addr_i;
            if (we_i) begin
              // A zero mask is still granted but must not disturb the array.
              sram_wen_o  = |wmask_i;
              sram_din_o  = wdata_i;
              sram_wbeb_o = ~wmask_i;
            end else begin
              sram_ren_o  = 1'b1;
            end
          end else begin
            sram_adr_o = '0;
          end
        end
        default: start_s = 1'b0;
      endcase
    end
  end

  // Read response: rvalid one cycle after an issued read; hold last read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_r <= 1'b0;
      hold_r   <= '0;
    end else begin
      rvalid_r <= sram_ren_o;
      if (rvalid_r) begin
        hold_r <= sram_q_i;
      end else begin
        hold_r <= hold_r;
      end
    end
  end

  assign rvalid_o    = rvalid_r;
  assign rdata_o     = rvalid_r ? sram_q_i : hold_r;
  assign init_done_o = ~rst_i && (state_r == IDLE);

  assign sram_mc_o       = McVal;
  assign sram_mcen_o     = 1'b0;
  assign sram_clkbyp_o   = 1'b0;
  assign sram_wa_o       = WaVal;
  assign sram_wpulse_o   = WpulseVal;
  assign sram_wpulseen_o = 1'b0;
  assign sram_fwen_o     = 1'b0;

endmodule

// File: tb/tb_sram_512x28_host_ctrl.sv
// Self-checking bench for sram_512x28_host_ctrl with a behavioural macro model.
module tb_sram_512x28_host_ctrl;

  logic        clk;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        we;
  logic [8:0]  addr;
  logic [27:0] wdata;
  logic [27:0] wmask;
  logic        rvalid;
  logic [27:0] rdata;
  logic        init_req;
  logic        init_done;
  logic        sram_ren;
  logic        sram_wen;
  logic [8:0]  sram_adr;
  logic [27:0] sram_din;
  logic [27:0] sram_wbeb;
  logic [27:0] sram_q;
  logic [2:0]  sram_mc;
  logic        sram_mcen;
  logic        sram_clkbyp;
  logic [1:0]  sram_wa;
  logic [1:0]  sram_wpulse;
  logic        sram_wpulseen;
  logic        sram_fwen;

  int n_checks = 0;
  int n_fail   = 0;

  logic [27:0] mem [512];

  sram_512x28_host_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .req_i           (req),
    .gnt_o           (gnt),
    .we_i            (we),
    .addr_i          (addr),
    .wdata_i         (wdata),
    .wmask_i         (wmask),
    .rvalid_o        (rvalid),
    .rdata_o         (rdata),
    .init_req_i      (init_req),
    .init_done_o     (init_done),
    .sram_ren_o      (sram_ren),
    .sram_wen_o      (sram_wen),
    .sram_adr_o      (sram_adr),
    .sram_din_o      (sram_din),
    .sram_wbeb_o     (sram_wbeb),
    .sram_q_i        (sram_q),
    .sram_mc_o       (sram_mc),
    .sram_mcen_o     (sram_mcen),
    .sram_clkbyp_o   (sram_clkbyp),
    .sram_wa_o       (sram_wa),
    .sram_wpulse_o   (sram_wpulse),
    .sram_wpulseen_o (sram_wpulseen),
    .sram_fwen_o     (sram_fwen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural macro: active-low bit write enables, registered read data.
  always @(posedge clk) begin
    if (sram_wen)
      mem[sram_adr] <= (mem[sram_adr] & sram_wbeb) | (sram_din & ~sram_wbeb);
    if (sram_ren)
      sram_q <= mem[sram_adr];
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Enters and leaves at a negedge. abort_at >= 0 returns at that init address.
  task automatic run_init(input int abort_at, input bit pulse_req);
    int k;
    k = 0;
    while (sram_wen !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    chk("init_start", {31'd0, sram_wen}, 32'd1);
    for (int i = 0; i < 512; i++) begin
      chk("init_wen",  {31'd0, sram_wen}, 32'd1);
      chk("init_adr",  {23'd0, sram_adr}, 32'(i));
      chk("init_din",  {4'd0, sram_din}, 32'd0);
      chk("init_wbeb", {4'd0, sram_wbeb}, 32'd0);
      chk("init_gnt",  {31'd0, gnt}, 32'd0);
      chk("init_ren",  {31'd0, sram_ren}, 32'd0);
      chk("init_done_low", {31'd0, init_done}, 32'd0);
      if (i == abort_at) return;
      @(posedge clk); #1;
      init_req = (pulse_req && i == 99);
      req      = pulse_req && i == 99;
      @(negedge clk);
    end
    init_req = 1'b0;
    req      = 1'b0;
    chk("init_done_rise", {31'd0, init_done}, 32'd1);
    chk("init_end_wen",   {31'd0, sram_wen}, 32'd0);
  endtask

  task automatic do_read(input logic [8:0] a, input logic [27:0] exp);
    @(posedge clk); #1;
    req = 1'b1; we = 1'b0; addr = a;
    @(negedge clk);
    chk("rd_gnt", {31'd0, gnt}, 32'd1);
    chk("rd_ren", {31'd0, sram_ren}, 32'd1);
    chk("rd_adr", {23'd0, sram_adr}, {23'd0, a});
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk);
    chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
    chk("rd_data",   {4'd0, rdata}, {4'd0, exp});
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [8:0]  addr;
    logic [27:0] wdata;
    logic [27:0] wmask;
    logic        init_req;
    logic        gnt;
    logic        ren;
    logic        wen;
    logic [27:0] wbeb;
    logic        rvalid;
    logic [27:0] rdata;
  } vec_t;

  vec_t vecs [14];

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 28'hFFFFFFF;
    sram_q = 28'h0;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = 9'd0;
    wdata = 28'h0; wmask = 28'h0; init_req = 1'b0;

    //            req   we    addr    wdata         wmask         ireq  gnt   ren   wen   wbeb          rvalid rdata
    vecs[0]  = '{1'b1, 1'b1, 9'd5,   28'h0ABCDEF, 28'hFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 28'h0000000, 1'b0, 28'h0000000};
    vecs[1]  = '{1'b1, 1'b0, 9'd5,   28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0000000};
    vecs[2]  = '{1'b0, 1'b0, 9'd0,   28'h0,       28'h0,       1'b0, 1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 1'b1, 28'h0ABCDEF};
    vecs[3]  = '{1'b0, 1'b0, 9'd0,   28'h0,       28'h0,       1'b0, 1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0ABCDEF};
    vecs[4]  = '{1'b1, 1'b1, 9'd5,   28'h0000005, 28'h000000F, 1'b0, 1'b1, 1'b0, 1'b1, 28'hFFFFFF0, 1'b0, 28'h0ABCDEF};
    vecs[5]  = '{1'b1, 1'b0, 9'd5,   28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0ABCDEF};
    vecs[6]  = '{1'b1, 1'b1, 9'd5,   28'h1234567, 28'h0000000, 1'b0, 1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 1'b1, 28'h0ABCDE5};
    vecs[7]  = '{1'b1, 1'b0, 9'd5,   28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0ABCDE5};
    vecs[8]  = '{1'b1, 1'b1, 9'd511, 28'hFEDCBA9, 28'hFFFFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 28'h0000000, 1'b1, 28'h0ABCDE5};
    vecs[9]  = '{1'b1, 1'b0, 9'd511, 28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0ABCDE5};
    vecs[10] = '{1'b1, 1'b0, 9'd0,   28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b1, 28'hFEDCBA9};
    vecs[11] = '{1'b0, 1'b0, 9'd0,   28'h0,       28'h0,       1'b0, 1'b1, 1'b0, 1'b0, 28'hFFFFFFF, 1'b1, 28'h0000000};
    vecs[12] = '{1'b1, 1'b0, 9'd5,   28'h0,       28'h0,       1'b0, 1'b1, 1'b1, 1'b0, 28'hFFFFFFF, 1'b0, 28'h0000000};
    vecs[13] = '{1'b1, 1'b0, 9'd0,   28'h0,       28'h0,       1'b1, 1'b0, 1'b0, 1'b0, 28'hFFFFFFF, 1'b1, 28'h0ABCDE5};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt",       {31'd0, gnt}, 32'd0);
    chk("rst_ren",       {31'd0, sram_ren}, 32'd0);
    chk("rst_wen",       {31'd0, sram_wen}, 32'd0);
    chk("rst_rvalid",    {31'd0, rvalid}, 32'd0);
    chk("rst_rdata",     {4'd0, rdata}, 32'd0);
    chk("rst_init_done", {31'd0, init_done}, 32'd0);
    chk("tieoffs", {20'd0, sram_mc, sram_mcen, sram_clkbyp, sram_wa, sram_wpulse,
                    sram_wpulseen, sram_fwen}, 32'd0);

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    run_init(-1, 1'b0);

    // Table-driven host traffic
    for (int v = 0; v < 14; v++) begin
      @(posedge clk); #1;
      req = vecs[v].req; we = vecs[v].we; addr = vecs[v].addr;
      wdata = vecs[v].wdata; wmask = vecs[v].wmask; init_req = vecs[v].init_req;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", v),    {31'd0, gnt}, {31'd0, vecs[v].gnt});
      chk($sformatf("v%0d_ren", v),    {31'd0, sram_ren}, {31'd0, vecs[v].ren});
      chk($sformatf("v%0d_wen", v),    {31'd0, sram_wen}, {31'd0, vecs[v].wen});
      chk($sformatf("v%0d_wbeb", v),   {4'd0, sram_wbeb}, {4'd0, vecs[v].wbeb});
      chk($sformatf("v%0d_rvalid", v), {31'd0, rvalid}, {31'd0, vecs[v].rvalid});
      chk($sformatf("v%0d_rdata", v),  {4'd0, rdata}, {4'd0, vecs[v].rdata});
      chk($sformatf("v%0d_done", v),   {31'd0, init_done}, 32'd1);
      if (vecs[v].gnt && vecs[v].req)
        chk($sformatf("v%0d_adr", v), {23'd0, sram_adr}, {23'd0, vecs[v].addr});
      if (vecs[v].gnt && vecs[v].req && vecs[v].we)
        chk($sformatf("v%0d_din", v), {4'd0, sram_din}, {4'd0, vecs[v].wdata});
    end

    // init_req with a concurrent read: INIT begins next cycle, init_req ignored inside
    @(posedge clk); #1;
    req = 1'b0; init_req = 1'b0;
    @(negedge clk);
    chk("reinit_wen",    {31'd0, sram_wen}, 32'd1);
    chk("reinit_adr",    {23'd0, sram_adr}, 32'd0);
    chk("reinit_done",   {31'd0, init_done}, 32'd0);
    chk("reinit_rvalid", {31'd0, rvalid}, 32'd0);
    chk("reinit_hold",   {4'd0, rdata}, 32'h00ABCDE5);
    run_init(-1, 1'b1);
    do_read(9'd5, 28'h0);
    do_read(9'd511, 28'h0);

    // Reset in the middle of an init pass restarts it from address 0
    @(posedge clk); #1;
    wdata = 28'h0; wmask = 28'h0;
    req = 1'b1; we = 1'b1; addr = 9'd7; wdata = 28'h7654321; wmask = 28'hFFFFFFF;
    @(posedge clk); #1;
    req = 1'b0; init_req = 1'b1;
    @(posedge clk); #1;
    init_req = 1'b0;
    @(negedge clk);
    run_init(200, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_wen",  {31'd0, sram_wen}, 32'd0);
    chk("midrst_done", {31'd0, init_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    run_init(-1, 1'b0);
    do_read(9'd7, 28'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
